multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the LEGv8 datapath: FETCH, DECODE, EXEC, MEM, WB.
- Decodes the same instruction subset and control encodings as the single-cycle decoder.
- Sequences PC, IR, register file, ALU and memory enables across cycles.
- Handshakes with instruction and data memories that may stall.
- Counts retired instructions and halts on an unsupported opcode.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high reset
- opcode  in  11  IR[31:21], sampled only in DECODE
- aluzero  in  1  ALU zero flag, sampled only in EXEC
- imem_ready  in  1  instruction memory completes fetch
- dmem_ready  in  1  data memory completes access
- imem_req  out  1  instruction fetch request
- irwrite  out  1  latch IR and old_pc
- pc_inc  out  1  PC <= PC+4
- pc_load  out  1  PC <= branch target (old_pc + ext imm)
- dmem_req  out  1  data memory request
- memread  out  1  data read
- memwrite  out  1  data write
- regwrite  out  1  register file write
- reg2loc, alusrc, mem2reg  out  1 each  datapath muxes
- aluop  out  4  ALU operation
- signop  out  3  sign-extender mode
- state  out  3  current state, for debug
- halted  out  1  unsupported opcode trapped
- instr_done  out  1  one-cycle retire pulse
- retired  out  CNT_W  count of retired instructions

Behaviour:
- Opcode classes, casez with first match in this order:
  - ANDREG ?0001010???
  - ORRREG ?0101010???
  - ADDREG ?0?01011???
  - SUBREG ?1?01011???
  - ADDIMM ?0?10001???
  - SUBIMM ?1?10001???
  - MOVZ 110100101??
  - B ?00101?????
  - CBZ ?011010????
  - LDUR ??111000010
  - STUR ??111000000
  - Anything else is ILLEGAL.
- aluop by class: AND 0000, ORR 0001, ADD/ADDIMM/LDUR/STUR 0010, SUB/SUBIMM 0110, MOVZ/B/CBZ 0111.
- signop by class: IMM 000, LDUR/STUR 001, B 010, CBZ 011, MOVZ {1, opcode[1:0]}. Register ops drive 000.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6–7 go to FETCH on the next edge.
- Class and MOVZ shift bits are registered at the end of DECODE. All outputs are combinational from state and the registered class, so opcode changes after DECODE have no effect.
- FETCH: imem_req=1, held until imem_ready.
  - On the imem_ready cycle: irwrite=1, pc_inc=1, then go to DECODE.
  - Otherwise stay in FETCH; all other enables 0.
- DECODE: one cycle. reg2loc=1 for CBZ/STUR, else 0.
  - ILLEGAL goes to HALT.
  - All others go to EXEC.
- EXEC: one cycle. alusrc=1 for IMM/MOVZ/LDUR/STUR. aluop and signop per class.
  - B: pc_load=1, instr_done=1, go to FETCH.
  - CBZ: pc_load=aluzero, instr_done=1, go to FETCH.
  - LDUR/STUR go to MEM.
  - Others go to WB.
- MEM: dmem_req=1. memread=1 for LDUR, memwrite=1 for STUR. alusrc, aluop and signop are held.
  - Request is held until dmem_ready.
  - On ready: LDUR goes to WB; STUR sets instr_done=1 and goes to FETCH.
- WB: one cycle. regwrite=1; mem2reg=1 for LDUR, else 0. instr_done=1, go to FETCH.
- HALT: absorbing. halted=1, all enables 0. Only Reset exits.
- retired increments on every instr_done and wraps modulo 2^CNT_W.
- pc_inc and pc_load are never both 1. No write enable is asserted outside the states listed above.
- Reset at an edge puts state in FETCH and clears class, retired and halted.
  - Reset overrides a concurrent imem_ready or dmem_ready.
  - A reset mid-MEM aborts the access: dmem_req is 0 in the cycle after the reset edge.
  - Following the reset edge, imem_req=1 and every other output is 0.
- A ready input asserted outside its matching request state is ignored.

Test Plan:
- ADDREG (opcode 10001011000), imem_ready held 1 → states 0,1,2,4; regwrite=1 only in WB with aluop 0010; retired=1 after 4 cycles.
- LDUR (11111000010), dmem_ready low 3 cycles → MEM held 4 cycles with dmem_req=1 and memread=1 throughout; WB mem2reg=1; 5+3 cycles total.
- CBZ (10110100xxx) with aluzero=1 → pc_load=1 in EXEC, no regwrite. Repeat with aluzero=0 → pc_load=0; both retire in 3 cycles.
- MOVZ (11010010110) → signop 110, alusrc=1, aluop 0111. STUR → memwrite=1 in MEM, retires without WB.
- Opcode 00000000000 → HALT, halted=1, retired unchanged, imem_ready ignored; Reset → FETCH, halted=0.
- Reset asserted in MEM with dmem_ready=1 the same cycle → no instr_done, retired=0, FETCH next with dmem_req=0. Separately, preload retired=2^CNT_W−1 and retire one instruction → retired wraps to 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the LEGv8 multi-cycle sequencer and its datapath and memories.
// The master side is the sequencer; the slave side is the datapath/memory environment.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [10:0]      opcode;
  logic             aluzero;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             irwrite;
  logic             pc_inc;
  logic             pc_load;
  logic             dmem_req;
  logic             memread;
  logic             memwrite;
  logic             regwrite;
  logic             reg2loc;
  logic             alusrc;
  logic             mem2reg;
  logic [3:0]       aluop;
  logic [2:0]       signop;
  logic [2:0]       state;
  logic             halted;
  logic             instr_done;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, aluzero, imem_ready, dmem_ready,
    output imem_req, irwrite, pc_inc, pc_load, dmem_req, memread, memwrite,
           regwrite, reg2loc, alusrc, mem2reg, aluop, signop, state, halted,
           instr_done, retired
  );

  modport slave (
    output opcode, aluzero, imem_ready, dmem_ready,
    input  imem_req, irwrite, pc_inc, pc_load, dmem_req, memread, memwrite,
           regwrite, reg2loc, alusrc, mem2reg, aluop, signop, state, halted,
           instr_done, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// LEGv8 multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with stalling memories,
// a retired-instruction counter and a halt trap on unsupported opcodes.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic                 CLK,
  input  logic                 Reset,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_AND, CL_ORR, CL_ADD, CL_SUB, CL_ADDI, CL_SUBI,
    CL_MOVZ, CL_B, CL_CBZ, CL_LDUR, CL_STUR, CL_ILL
  } cls_t;

  state_t           state_q, state_d;
  cls_t             cls_q, cls_dec;
  logic [1:0]       hw_q;
  logic [CNT_W-1:0] retired_q;

  logic       imem_req, irwrite, pc_inc, pc_load, dmem_req, memread, memwrite;
  logic       regwrite, reg2loc, alusrc, mem2reg, instr_done;
  logic [3:0] aluop;
  logic [2:0] signop;

  // First matching pattern wins; overlapping encodings rely on this order.
  function automatic cls_t decode_class(input logic [10:0] op);
    casez (op)
      11'b?0001010???: decode_class = CL_AND;
      11'b?0101010???: decode_class = CL_ORR;
      11'b?0?01011???: decode_class = CL_ADD;
      11'b?1?01011???: decode_class = CL_SUB;
      11'b?0?10001???: decode_class = CL_ADDI;
      11'b?1?10001???: decode_class = CL_SUBI;
      11'b110100101??: decode_class = CL_MOVZ;
      11'b?00101?????: decode_class = CL_B;
      11'b?011010????: decode_class = CL_CBZ;
      11'b??111000010: decode_class = CL_LDUR;
      11'b??111000000: decode_class = CL_STUR;
      default:         decode_class = CL_ILL;
    endcase
  endfunction

  function automatic logic [3:0] aluop_of(input cls_t c);
    case (c)
      CL_AND:                aluop_of = 4'b0000;
      CL_ORR:                aluop_of = 4'b0001;
      CL_SUB, CL_SUBI:       aluop_of = 4'b0110;
      CL_MOVZ, CL_B, CL_CBZ: aluop_of = 4'b0111;
      default:               aluop_of = 4'b0010;
    endcase
  endfunction

  function automatic logic [2:0] signop_of(input cls_t c, input logic [1:0] hw);
    case (c)
      CL_LDUR, CL_STUR: signop_of = 3'b001;
      CL_B:             signop_of = 3'b010;
      CL_CBZ:           signop_of = 3'b011;
      CL_MOVZ:          signop_of = {1'b1, hw};
      default:          signop_of = 3'b000;
    endcase
  endfunction

  function automatic logic alusrc_of(input cls_t c);
    case (c)
      CL_ADDI, CL_SUBI, CL_MOVZ, CL_LDUR, CL_STUR: alusrc_of = 1'b1;
      default:                                     alusrc_of = 1'b0;
    endcase
  endfunction

  assign cls_dec = decode_class(bus.opcode);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      cls_q     <= CL_AND;
      hw_q      <= 2'b00;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        cls_q <= cls_dec;
        hw_q  <= bus.opcode[1:0];
      end
      if (instr_done) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    irwrite    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    dmem_req   = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    reg2loc    = 1'b0;
    alusrc     = 1'b0;
    mem2reg    = 1'b0;
    aluop      = 4'b0000;
    signop     = 3'b000;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          irwrite = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      // Register read port selection happens while the opcode is still live.
      S_DECODE: begin
        reg2loc = (cls_dec == CL_CBZ) || (cls_dec == CL_STUR);
        state_d = (cls_dec == CL_ILL) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alusrc = alusrc_of(cls_q);
        aluop  = aluop_of(cls_q);
        signop = signop_of(cls_q, hw_q);
        case (cls_q)
          CL_B: begin
            pc_load    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          CL_CBZ: begin
            pc_load    = bus.aluzero;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          CL_LDUR, CL_STUR: state_d = S_MEM;
          default:          state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        memread  = (cls_q == CL_LDUR);
        memwrite = (cls_q == CL_STUR);
        alusrc   = alusrc_of(cls_q);
        aluop    = aluop_of(cls_q);
        signop   = signop_of(cls_q, hw_q);
        if (bus.dmem_ready) begin
          if (cls_q == CL_LDUR) begin
            state_d = S_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end
      end
      // ALU controls stay asserted so the result path is stable during the write.
      S_WB: begin
        regwrite   = 1'b1;
        mem2reg    = (cls_q == CL_LDUR);
        alusrc     = alusrc_of(cls_q);
        aluop      = aluop_of(cls_q);
        signop     = signop_of(cls_q, hw_q);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.imem_req   = imem_req;
  assign bus.irwrite    = irwrite;
  assign bus.pc_inc     = pc_inc;
  assign bus.pc_load    = pc_load;
  assign bus.dmem_req   = dmem_req;
  assign bus.memread    = memread;
  assign bus.memwrite   = memwrite;
  assign bus.regwrite   = regwrite;
  assign bus.reg2loc    = reg2loc;
  assign bus.alusrc     = alusrc;
  assign bus.mem2reg    = mem2reg;
  assign bus.aluop      = aluop;
  assign bus.signop     = signop;
  assign bus.state      = state_q;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.instr_done = instr_done;
  assign bus.retired    = retired_q;

endmodule
